// File: rtl/fp_cdb_arbiter.sv
//==============================================================================
// fp_cdb_arbiter: one-deep holding buffers per FP FU feeding a shared CDB slot
// Revision: 1.0
//==============================================================================
`default_nettype none

package riscv_pkg;
  localparam int ReorderBufferTagWidth = 5;

  typedef struct packed {
    logic                             valid;
    logic [ReorderBufferTagWidth-1:0] tag;
    logic [63:0]                      value;
    logic                             exception;
    logic [4:0]                       exc_cause;
    logic [4:0]                       fp_flags;
  } fu_complete_t;
endpackage

module fp_cdb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  riscv_pkg::fu_complete_t                       i_fu_complete [NUM_REQ],
  output logic [NUM_REQ-1:0]                            o_hold_full,
  output riscv_pkg::fu_complete_t                       o_cdb,
  input  logic                                          i_cdb_ready,
  output logic [NUM_REQ-1:0]                            o_grant,
  input  logic                                          i_flush,
  input  logic                                          i_flush_en,
  input  logic [riscv_pkg::ReorderBufferTagWidth-1:0]   i_flush_tag,
  input  logic [riscv_pkg::ReorderBufferTagWidth-1:0]   i_rob_head_tag,
  output logic                                          o_overflow
);

  localparam int c_tw = riscv_pkg::ReorderBufferTagWidth;
  localparam int c_pw = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  riscv_pkg::fu_complete_t r_buf [NUM_REQ];
  logic [NUM_REQ-1:0]      r_valid;
  logic [c_pw-1:0]         r_ptr;
  logic                    r_ovf;

  logic [NUM_REQ-1:0]      w_kill_buf;
  logic [NUM_REQ-1:0]      w_kill_in;
  logic [NUM_REQ-1:0]      w_elig;
  logic [NUM_REQ-1:0]      w_free;
  logic [NUM_REQ-1:0]      w_take;
  logic [NUM_REQ-1:0]      w_grant;
  logic [c_pw-1:0]         w_win;
  logic [c_pw-1:0]         w_idx;
  logic [c_pw-1:0]         w_ptr_nxt;
  logic                    w_any;
  logic                    w_hs;

  // Age is the distance from the ROB head, so wrapped tags compare correctly.
  function automatic logic f_younger(input logic [c_tw-1:0] tag,
                                     input logic [c_tw-1:0] ftag,
                                     input logic [c_tw-1:0] head);
    logic [c_tw:0] a_tag;
    logic [c_tw:0] a_flush;
    a_tag   = {1'b0, tag}  - {1'b0, head};
    a_flush = {1'b0, ftag} - {1'b0, head};
    return a_tag > a_flush;
  endfunction

  always_comb begin
    w_kill_buf = '0;
    w_kill_in  = '0;
    w_elig     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_kill_buf[i] = i_flush | (i_flush_en & f_younger(r_buf[i].tag, i_flush_tag, i_rob_head_tag));
      w_kill_in[i]  = i_flush | (i_flush_en & f_younger(i_fu_complete[i].tag, i_flush_tag, i_rob_head_tag));
      w_elig[i]     = r_valid[i] & ~w_kill_buf[i];
    end
  end

  // Round-robin search starting at the pointer; flushed entries are already excluded.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = c_pw'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    o_cdb   = '0;
    w_grant = '0;
    if (w_any) begin
      o_cdb       = r_buf[w_win];
      o_cdb.valid = 1'b1;
      w_grant     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    end
  end

  assign o_grant   = w_grant;
  assign w_hs      = w_any & i_cdb_ready;
  assign w_ptr_nxt = (w_win == c_pw'(NUM_REQ - 1)) ? '0 : w_win + c_pw'(1);

  always_comb begin
    w_free = '0;
    w_take = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_free[i] = ~r_valid[i] | w_kill_buf[i] | (w_hs & w_grant[i]);
      w_take[i] = i_fu_complete[i].valid & ~w_kill_in[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_take[i] && w_free[i]) begin
          r_valid[i] <= 1'b1;
          r_buf[i]   <= i_fu_complete[i];
        end else if (w_free[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_hs) begin
        r_ptr <= w_ptr_nxt;
      end
      // A survivor landing on an occupied, non-draining buffer is dropped.
      if (|(w_take & ~w_free)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_hold_full = r_valid;
  assign o_overflow  = r_ovf;

endmodule

`default_nettype wire
